qblock_sprite_ctrl: RTL and testbench

- Per-block controller for one 20x20 question block. Sits directly upstream of the block sprite ROMs: active (question) and empty variants, each with a 9-bit read_address in and a 24-bit output_color out.
- From the VGA scan position it computes the ROM read address and selects the ROM variant. It also runs the hit -> bump-animation -> empty state machine.
- Outputs a pixel-valid flag to the colour mapper.

---
 rtl/qblock_pkg.sv | 15 +
 rtl/frame_tick_sync.sv | 26 ++
 rtl/qblock_sprite_ctrl.sv | 122 ++++++++++++
 tb/tb_qblock_sprite_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/qblock_pkg.sv
// Shared types and constants for the question-block sprite controller.
package qblock_pkg;

  typedef enum logic [1:0] {ACTIVE, BUMP, EMPTY} qblock_state_t;

  localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;
  localparam int          SPRITE_DIM_DEF  = 20;

  // Vertical lift for a given bump frame: rises for the first half, falls for the second.
  function automatic logic [9:0] bump_offset(input int cnt, input int frames, input int step);
    if (cnt < frames / 2) return 10'(step * (cnt + 1));
    else                  return 10'(step * (frames - cnt));
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame clock into the pixel clock domain and emits
// a one-cycle pulse per rising edge, three cycles after the edge.
module frame_tick_sync (
  input  logic gclk,
  input  logic grst_n,
  input  logic async_in,
  output logic tick
);

  logic [1:0] sync;
  logic       prev;

  // Two-flop synchroniser, edge-history flop, registered rising-edge pulse.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[0], async_in};
      prev <= sync[1];
      tick <= sync[1] & ~prev;
    end
  end

endmodule

// File: rtl/qblock_sprite_ctrl.sv
// Question-block sprite controller: scan-position to ROM address mapping,
// sprite variant select, and the hit -> bump -> empty animation.
// Optional macro QBLOCK_TRANSPARENT_EN: treats the palette key colour as
// transparent so the rounded corners show the background.
module qblock_sprite_ctrl
  import qblock_pkg::*;
#(
  parameter logic [9:0] BLK_X       = 10'd200,
  parameter logic [9:0] BLK_Y       = 10'd300,
  parameter int         SPRITE_DIM  = SPRITE_DIM_DEF,
  parameter int         BUMP_FRAMES = 8,
  parameter int         BUMP_STEP   = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hit,
  input  logic [23:0] rom_color,
  output logic [8:0]  read_address,
  output logic        rom_sel,
  output logic        pixel_on,
  output logic        block_empty,
  output logic        coin_spawn
);

  localparam int CW     = $clog2(BUMP_FRAMES);
  localparam int STAGES = 1;

  qblock_state_t  state, state_nxt;
  logic [CW-1:0]  bump_cnt, cnt_nxt;
  logic [9:0]     offset, off_nxt;
  logic           frame_tick;
  logic [9:0]     col, row, top;
  logic           in_block;
  logic [8:0]     address;
  logic [STAGES:1] vld_pipe;
  logic           inb_d;

  frame_tick_sync u_frame_sync (
    .gclk     (Clk),
    .grst_n   (Reset_n),
    .async_in (frame_clk),
    .tick     (frame_tick)
  );

  // Next state and bump counter; hits only count while the block is fresh.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bump_cnt;
    case (state)
      ACTIVE: if (hit) begin
        state_nxt = BUMP;
        cnt_nxt   = '0;
      end
      BUMP: if (frame_tick) begin
        if (bump_cnt == CW'(BUMP_FRAMES - 1)) begin
          state_nxt = EMPTY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bump_cnt + CW'(1);
        end
      end
      EMPTY: ;
      default: begin
        state_nxt = ACTIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Offset follows the next state so it drops to zero the cycle the bump ends.
  always_comb begin
    off_nxt = '0;
    if (state_nxt == BUMP) off_nxt = bump_offset(int'(cnt_nxt), BUMP_FRAMES, BUMP_STEP);
  end

  // Sprite-relative coordinates; negatives wrap large and fail the range test.
  always_comb begin
    top      = BLK_Y - offset;
    col      = DrawX - BLK_X;
    row      = DrawY - top;
    in_block = (col < 10'(SPRITE_DIM)) && (row < 10'(SPRITE_DIM));
    address  = 9'(row) * 9'(SPRITE_DIM) + 9'(col);
  end

  // State, animation and one-cycle address/select pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ACTIVE;
      bump_cnt     <= '0;
      offset       <= '0;
      read_address <= '0;
      rom_sel      <= 1'b0;
      vld_pipe     <= '0;
      block_empty  <= 1'b0;
      coin_spawn   <= 1'b0;
    end else begin
      state        <= state_nxt;
      bump_cnt     <= cnt_nxt;
      offset       <= off_nxt;
      read_address <= in_block ? address : 9'd0;
      rom_sel      <= (state != ACTIVE);
      vld_pipe[1]  <= in_block;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      block_empty  <= (state == EMPTY);
      coin_spawn   <= (state == ACTIVE) && hit;
    end
  end

  assign inb_d = vld_pipe[STAGES];

`ifdef QBLOCK_TRANSPARENT_EN
  // Key colour pixels are left to the background.
  assign pixel_on = inb_d && (rom_color != TRANSPARENT_KEY);
`else
  // Whole square drawn; the key term is absorbed and reduces to inb_d.
  assign pixel_on = inb_d | (inb_d & (rom_color == TRANSPARENT_KEY));
`endif

endmodule

// File: tb/tb_qblock_sprite_ctrl.sv
// Self-checking bench for qblock_sprite_ctrl: frame-level behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_qblock_sprite_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY;
  logic        hit;
  logic [23:0] rom_color;
  logic [8:0]  read_address;
  logic        rom_sel, pixel_on, block_empty, coin_spawn;

  qblock_sprite_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .hit(hit), .rom_color(rom_color), .read_address(read_address), .rom_sel(rom_sel),
    .pixel_on(pixel_on), .block_empty(block_empty), .coin_spawn(coin_spawn)
  );

  always #10 Clk = ~Clk;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 fresh, 1 bumping, 2 used; frames = frame edges seen while bumping.
  int bump_tbl [8] = '{2, 4, 6, 8, 8, 6, 4, 2};
  int m_phase = 0, m_frames = 0, m_off = 0;
  bit [4:0] fch = '0;
  int exp_addr = 0;
  bit exp_rs = 0, exp_inb = 0, exp_empty = 0, exp_coin = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_phase = 0; m_frames = 0; m_off = 0; fch = '0;
      exp_addr = 0; exp_rs = 0; exp_inb = 0; exp_empty = 0; exp_coin = 0;
    end else begin
      int col, row;
      bit inb, tk;
      fch = {fch[3:0], frame_clk};
      tk  = fch[3] & ~fch[4];
      col = (int'(DrawX) - 200) & 1023;
      row = (int'(DrawY) - 300 + m_off) & 1023;
      inb = (col < 20) && (row < 20);
      exp_addr  = inb ? row * 20 + col : 0;
      exp_inb   = inb;
      exp_rs    = (m_phase != 0);
      exp_empty = (m_phase == 2);
      exp_coin  = (m_phase == 0) && hit;
      if (m_phase == 0 && hit) begin
        m_phase = 1; m_frames = 0;
      end else if (m_phase == 1 && tk) begin
        m_frames++;
        if (m_frames == 8) m_phase = 2;
      end
      m_off = (m_phase == 1) ? bump_tbl[m_frames] : 0;
    end
  end

  function automatic bit exp_pix();
`ifdef QBLOCK_TRANSPARENT_EN
    return exp_inb && (rom_color != 24'h800080);
`else
    return exp_inb;
`endif
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_read_address", read_address, exp_addr);
      chk("m_rom_sel", rom_sel, exp_rs);
      chk("m_pixel_on", pixel_on, exp_pix());
      chk("m_block_empty", block_empty, exp_empty);
      chk("m_coin_spawn", coin_spawn, exp_coin);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge Clk); #1; end
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1; cyc(4);
    frame_clk = 1'b0; cyc(4);
  endtask

  task automatic probe(input string name, input int x, input int y, input int a, input int p);
    DrawX = 10'(x); DrawY = 10'(y); cyc(1);
    chk({name, "_addr"}, read_address, a);
    chk({name, "_pix"}, pixel_on, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1; frame_clk = 0; DrawX = 0; DrawY = 0; hit = 0; rom_color = 24'hE75A10;
    #2 Reset_n = 0;
    #1 chk_en = 1;
    cyc(2);
    chk("rst_addr", read_address, 0);
    chk("rst_rom_sel", rom_sel, 0);
    chk("rst_empty", block_empty, 0);
    chk("rst_coin", coin_spawn, 0);
    Reset_n = 1; cyc(2);

    // Address mapping and edges
    probe("a65", 205, 303, 65, 1);
    chk("a65_sel", rom_sel, 0);
    probe("a399", 219, 319, 399, 1);
    probe("x220", 220, 319, 0, 0);
    probe("x199", 199, 300, 0, 0);
    probe("x200", 200, 300, 0, 1);
    probe("y299", 210, 299, 0, 0);

    // Hit and bump sequence
    DrawX = 200; DrawY = 300;
    hit = 1; cyc(1); hit = 0;
    chk("coin_on", coin_spawn, 1);
    cyc(1);
    chk("coin_once", coin_spawn, 0);
    chk("bump_sel", rom_sel, 1);
    for (int f = 0; f < 8; f++) begin
      probe("off_top", 200, 300 - bump_tbl[f], 0, 1);
      probe("off_above", 200, 299 - bump_tbl[f], 0, 0);
      if (f == 3) probe("off8_292", 200, 292, 0, 1);
      if (f == 1) begin
        hit = 1; cyc(1); hit = 0;
        chk("hit_bump_ignored", coin_spawn, 0);
        probe("off_kept", 200, 296, 0, 1);
      end
      frame_pulse();
    end
    cyc(2);
    chk("empty_set", block_empty, 1);
    probe("empty_rest", 200, 300, 0, 1);
    hit = 1; cyc(1); hit = 0;
    chk("hit_empty_ignored", coin_spawn, 0);
    frame_pulse();
    chk("empty_kept", block_empty, 1);
    chk("empty_sel", rom_sel, 1);

    // Simultaneous hit and frame tick
    Reset_n = 0; cyc(1); Reset_n = 1; cyc(2);
    chk("rerst_empty", block_empty, 0);
    chk("rerst_sel", rom_sel, 0);
    frame_clk = 1; cyc(3);
    hit = 1; cyc(1); hit = 0;
    chk("sim_coin", coin_spawn, 1);
    probe("sim_off2", 200, 298, 0, 1);
    probe("sim_not4", 200, 296, 0, 0);
    frame_clk = 0; cyc(3);

    // Reset in the middle of the bump (bump_cnt = 3)
    frame_pulse(); frame_pulse(); frame_pulse();
    probe("mid_in", 205, 295, 65, 1);
    chk("mid_sel", rom_sel, 1);
    #3 Reset_n = 0;
    #1;
    chk("async_addr", read_address, 0);
    chk("async_sel", rom_sel, 0);
    chk("async_pix", pixel_on, 0);
    chk("async_empty", block_empty, 0);
    chk("async_coin", coin_spawn, 0);
    cyc(2); Reset_n = 1; cyc(1);
    chk("post_sel", rom_sel, 0);
    probe("post_a65", 205, 303, 65, 1);

    // Transparency key
    rom_color = 24'h800080; cyc(1);
`ifdef QBLOCK_TRANSPARENT_EN
    chk("key_pix", pixel_on, 0);
`else
    chk("key_pix", pixel_on, 1);
`endif
    rom_color = 24'hE75A10; cyc(1);
    chk("color_pix", pixel_on, 1);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
